mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter WORDS, default 64, the depth in 32-bit words of the attached single-port memory.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(WORDS), the word-address width of the memory port.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 req_valid  in  1  core request present.
REQ-006 req_ready  out  1  block can accept a request (high only in IDLE).
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  zero-extend sub-word loads when 1.
REQ-011 req_wdata  in  32  store data, LSB-justified.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  32  formatted load data (0 for stores and errors).
REQ-014 resp_error  out  1  request misaligned or illegal; qualified by resp_valid.
REQ-015 mem_address  out  ADDR_WIDTH  word index to memory.
REQ-016 mem_write_data  out  32  full word to memory.
REQ-017 mem_write_enable  out  1  memory write strobe.
REQ-018 mem_read_data  in  32  memory output; registered in memory, valid the cycle after mem_address is presented.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, CAPTURE, WRITE, RESP; one request outstanding at most.
REQ-020 Accept = req_valid & req_ready at a rising edge; SHALL latch addr, size, write, unsigned, wdata; inputs ignored until return to IDLE.
REQ-021 Word index SHALL be addr_q[ADDR_WIDTH+1:2]; higher address bits ignored (index wraps modulo WORDS).
REQ-022 Error = size 11, or half with addr[0]=1, or word with addr[1:0]!=0; SHALL go IDLE->RESP, resp_error=1, resp_rdata=0, no memory write.
REQ-023 Load: IDLE->ISSUE (drive mem_address)->CAPTURE (sample mem_read_data, format)->RESP; resp_valid high 3 cycles after accept edge.
REQ-024 Load format: select lane by addr_q[1:0] (byte) or addr_q[1] (half); sign-extend from bit 7/15 unless unsigned; word passed unchanged.
REQ-025 Word store: IDLE->WRITE (mem_write_enable=1, mem_write_data=wdata_q)->RESP; resp_valid 2 cycles after accept.
REQ-026 Sub-word store (read-modify-write): IDLE->ISSUE->CAPTURE (merge wdata_q[7:0] or [15:0] into addressed lane of mem_read_data, other lanes preserved)->WRITE->RESP; resp_valid 4 cycles after accept.
REQ-027 mem_write_enable SHALL be high only in WRITE, for exactly one cycle per store.
REQ-028 mem_address SHALL equal the latched word index in every non-IDLE state.
REQ-029 RESP SHALL last one cycle and return to IDLE; resp_valid has no back-pressure; a new request can be accepted the cycle after RESP.
REQ-030 resp_rdata and resp_error SHALL hold their values until the next RESP.
REQ-031 Store responses SHALL have resp_rdata=0, resp_error=0.

Reset
REQ-032 While rst is high: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_address=0, mem_write_data=0, all latched fields 0.
REQ-033 rst asserted mid-operation SHALL abort immediately with no further write strobe and no response for the aborted request.

Verification
REQ-034 Word store addr 0x08 data 0xDEADBEEF, then word load 0x08 -> one write strobe at index 2; load resp_rdata=0xDEADBEEF 3 cycles after accept.
REQ-035 Memory index 1 = 0x11223344; byte store 0xAA to 0x06 -> index 1 becomes 0x11AA3344; signed byte load 0x06 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-036 Half load 0x03 and word load 0x02 -> resp_error=1 1 cycle after accept, resp_rdata=0, no mem_write_enable; size 11 likewise.
REQ-037 Word store at byte address 4*WORDS+4 -> write lands at index 1 (wrap).
REQ-038 rst pulsed during CAPTURE of a half store -> no write strobe, no resp_valid, req_ready=1 after rst falls, target word unchanged.
REQ-039 Back-to-back requests with req_valid held high -> req_ready low during each operation, each accepted exactly once, responses in order.

Source files
------------

// File: rtl/mem_requester.sv
// Load/store requester: accepts one core request at a time and drives a single-port word memory,
// formatting sub-word loads and doing read-modify-write for sub-word stores.
module mem_requester #(
  parameter int WORDS      = 64,
  parameter int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_write_enable,
  input  logic [31:0]           mem_read_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic                  unsigned_q, unsigned_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  req_bad;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_fmt;
  logic [31:0]           merged;

  // Address bits above the memory index are deliberately ignored so the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  assign req_bad = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    lane_byte = mem_read_data[7:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_read_data[7:0];
      2'd1:    lane_byte = mem_read_data[15:8];
      2'd2:    lane_byte = mem_read_data[23:16];
      default: lane_byte = mem_read_data[31:24];
    endcase
  end

  assign lane_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

  always_comb begin
    load_fmt = mem_read_data;
    case (size_q)
      2'b00:   load_fmt = unsigned_q ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
      2'b01:   load_fmt = unsigned_q ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
      default: load_fmt = mem_read_data;
    endcase
  end

  // Store merge: addressed lanes take the low store bytes, the rest keep the memory word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic byte_hit, half_hit;
      assign byte_hit = (size_q == 2'b00) && (addr_q[1:0] == LANE);
      assign half_hit = (size_q == 2'b01) && (addr_q[1] == LANE[1]);
      assign merged[8*gi +: 8] = byte_hit ? data_q[7:0] :
                                 half_hit ? data_q[8*(gi%2) +: 8] :
                                            mem_read_data[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    data_d     = data_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr[ADDR_WIDTH+1:0];
          size_d     = req_size;
          write_d    = req_write;
          unsigned_d = req_unsigned;
          data_d     = req_wdata;
          if (req_bad) begin
            state_d = S_RESP;
            rdata_d = 32'd0;
            error_d = 1'b1;
          end else if (req_write && (req_size == 2'b10)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (write_q) begin
          data_d  = merged;
          state_d = S_WRITE;
        end else begin
          rdata_d = load_fmt;
          error_d = 1'b0;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d = 32'd0;
        error_d = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      data_q     <= 32'd0;
      rdata_q    <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      data_q     <= data_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign mem_write_enable = (state_q == S_WRITE);
  assign mem_address      = addr_q[ADDR_WIDTH+1:2];
  assign mem_write_data   = data_q;
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: table-driven requests against a registered-read memory model,
// responses and write strobes checked through scoreboard queues.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [5:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;
  logic        mem_write_enable;

  mem_requester #(.WORDS(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] tb_mem [0:63];
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'd0;

  always @(posedge clk) begin
    if (pre_en) tb_mem[pre_idx] <= pre_val;
    else if (mem_write_enable) tb_mem[mem_address] <= mem_write_data;
    mem_read_data <= tb_mem[mem_address];
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_wr;
    logic [5:0]  widx;
    logic [31:0] wword;
  } vec_t;

  typedef struct { logic [31:0] rdata; logic err; int lat; int acc; } sb_t;
  typedef struct { logic [5:0] idx; logic [31:0] word; } wr_t;

  vec_t tbl[$];
  vec_t b2b[$];
  sb_t  sbq[$];
  wr_t  wq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nresp = 0;

  function automatic vec_t mk(logic wr, logic [31:0] addr, logic [1:0] size, logic uns,
                              logic [31:0] wdata, logic [31:0] rdata, logic err, int lat,
                              logic ew, int widx, logic [31:0] wword);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat;
    v.exp_wr = ew; v.widx = 6'(widx); v.wword = wword;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every clock advance samples outputs on the falling edge and services the scoreboards.
  task automatic tick();
    sb_t e;
    wr_t w;
    @(negedge clk);
    cyc++;
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got rdata=%h err=%0b, expected none (cycle %0d)",
                 resp_rdata, resp_error, cyc);
      end else begin
        e = sbq.pop_front();
        nresp++;
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        $display("resp %0d: rdata=%h err=%0b latency=%0d", nresp, resp_rdata, resp_error,
                 cyc - e.acc + 1);
      end
    end
    if (mem_write_enable) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got idx=%0d data=%h, expected none (cycle %0d)",
                 mem_address, mem_write_data, cyc);
      end else begin
        w = wq.pop_front();
        chk("write_index", {26'd0, mem_address}, {26'd0, w.idx});
        chk("write_data", mem_write_data, w.word);
      end
    end
  endtask

  task automatic drive(vec_t v, bit hold);
    sb_t e;
    wr_t w;
    int  n;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 60) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got req_ready=0, expected 1 within 60 cycles");
      req_valid = 1'b0;
    end else begin
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.acc = cyc + 1;
      sbq.push_back(e);
      if (v.exp_wr) begin
        w.idx = v.widx; w.word = v.wword;
        wq.push_back(w);
      end
      tick();
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic preload(int idx, logic [31:0] val);
    pre_en = 1'b1; pre_idx = 6'(idx); pre_val = val;
    tick();
    pre_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_size = 2'b00;
    req_unsigned = 1'b0; req_wdata = 32'd0;

    //        wr  addr     sz uns wdata         rdata          err lat wr idx word
    tbl.push_back(mk(1, 'h08,  2, 0, 'hDEADBEEF, 'h0,          0, 2, 1, 2, 'hDEADBEEF));
    tbl.push_back(mk(0, 'h08,  2, 0, 'h0,        'hDEADBEEF,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(1, 'h06,  0, 0, 'h123456AA, 'h0,          0, 4, 1, 1, 'h11AA3344));
    tbl.push_back(mk(0, 'h06,  0, 0, 'h0,        'hFFFFFFAA,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h06,  0, 1, 'h0,        'h000000AA,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h04,  2, 0, 'h0,        'h11AA3344,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h03,  1, 0, 'h0,        'h0,          1, 1, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h02,  2, 0, 'h0,        'h0,          1, 1, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h00,  3, 0, 'h0,        'h0,          1, 1, 0, 0, 'h0));
    tbl.push_back(mk(1, 'h03,  1, 0, 'hFFFF,     'h0,          1, 1, 0, 0, 'h0));
    tbl.push_back(mk(1, 'h01,  2, 0, 'h12345678, 'h0,          1, 1, 0, 0, 'h0));
    tbl.push_back(mk(1, 'h104, 2, 0, 'hCAFEF00D, 'h0,          0, 2, 1, 1, 'hCAFEF00D));
    tbl.push_back(mk(0, 'h04,  2, 0, 'h0,        'hCAFEF00D,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(1, 'h0A,  1, 0, 'hFFFF8001, 'h0,          0, 4, 1, 2, 'h8001BEEF));
    tbl.push_back(mk(0, 'h0A,  1, 0, 'h0,        'hFFFF8001,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h0A,  1, 1, 'h0,        'h00008001,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h08,  1, 0, 'h0,        'hFFFFBEEF,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h0B,  0, 0, 'h0,        'hFFFFFF80,   0, 3, 0, 0, 'h0));
    tbl.push_back(mk(0, 'h09,  0, 1, 'h0,        'h000000BE,   0, 3, 0, 0, 'h0));

    b2b.push_back(mk(1, 'h10,  2, 0, 'h0BADF00D, 'h0,          0, 2, 1, 4, 'h0BADF00D));
    b2b.push_back(mk(0, 'h11,  0, 1, 'h0,        'h000000F0,   0, 3, 0, 0, 'h0));
    b2b.push_back(mk(0, 'h00,  3, 1, 'h0,        'h0,          1, 1, 0, 0, 'h0));
    b2b.push_back(mk(0, 'h12,  1, 0, 'h0,        'h00000BAD,   0, 3, 0, 0, 'h0));
    b2b.push_back(mk(1, 'h13,  0, 0, 'hFF,       'h0,          0, 4, 1, 4, 'hFFADF00D));
    b2b.push_back(mk(0, 'h10,  2, 0, 'h0,        'hFFADF00D,   0, 3, 0, 0, 'h0));
    b2b.push_back(mk(0, 'h13,  0, 0, 'h0,        'hFFFFFFFF,   0, 3, 0, 0, 'h0));

    tick();
    preload(1, 32'h11223344);
    preload(3, 32'h55667788);
    tick();
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_error", {31'd0, resp_error}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_mem_we", {31'd0, mem_write_enable}, 32'd0);
    chk("reset_mem_address", {26'd0, mem_address}, 32'd0);
    chk("reset_mem_wdata", mem_write_data, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], 1'b0);
      tick();
    end
    drain();

    // Back-to-back: req_valid stays high, next request presented while busy.
    for (int i = 0; i < b2b.size(); i++) begin
      drive(b2b[i], (i != b2b.size() - 1));
    end
    drain();
    chk("b2b_resp_count", 32'(nresp), 32'(tbl.size() + b2b.size()));

    // Abort a half store at index 3 while it is in CAPTURE.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0C; req_size = 2'b01;
    req_unsigned = 1'b0; req_wdata = 32'h00001234;
    chk("abort_ready_before", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("abort_issue_address", {26'd0, mem_address}, 32'd3);
    chk("abort_issue_ready", {31'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rst_we", {31'd0, mem_write_enable}, 32'd0);
    chk("abort_rst_address", {26'd0, mem_address}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_word_kept", tb_mem[3], 32'h55667788);

    drive(mk(0, 'h0C, 2, 0, 'h0, 'h55667788, 0, 3, 0, 0, 'h0), 1'b0);
    drain();
    chk("final_write_queue", 32'(wq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
